branch_target_buffer: RTL and testbench

Tagged, direct-mapped branch target buffer with per-entry saturating direction counters, parametrised in PC width, depth, tag width and counter width. Sits beside the IF stage: the fetch PC is looked up combinationally to produce a taken/target prediction. The resolving stage updates the buffer with the actual branch outcome. A multi-cycle invalidate sweep and mispredict statistics support context switches and performance debug.

---
 rtl/branch_target_buffer_pkg.sv | 31 +++
 rtl/btb_sat_counter.sv | 21 ++
 rtl/branch_target_buffer.sv | 137 +++++++++++++
 tb/tb_branch_target_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared FSM encoding and PC field extraction for the BTB
package branch_target_buffer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } btb_state_e;

  // Widest PC the field helpers accept; callers zero-extend into it.
  localparam int unsigned PC_MAX_W = 128;

  function automatic logic [PC_MAX_W-1:0] pc_field(input logic [PC_MAX_W-1:0] pc,
                                                   input int unsigned lsb,
                                                   input int unsigned width);
    logic [PC_MAX_W-1:0] mask;
    mask = (PC_MAX_W'(1) << width) - PC_MAX_W'(1);
    return (pc >> lsb) & mask;
  endfunction

  function automatic logic [PC_MAX_W-1:0] pc_index(input logic [PC_MAX_W-1:0] pc,
                                                   input int unsigned index_bits);
    return pc_field(pc, 2, index_bits);
  endfunction

  function automatic logic [PC_MAX_W-1:0] pc_tag(input logic [PC_MAX_W-1:0] pc,
                                                 input int unsigned index_bits,
                                                 input int unsigned tag_bits);
    return pc_field(pc, 2 + index_bits, tag_bits);
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// rtl/btb_sat_counter.sv - saturating up/down direction counter next-value function
module btb_sat_counter #(
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 up_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  always_comb begin
    cnt_o = cnt_i;
    if (up_i) begin
      if (cnt_i != CMAX) cnt_o = cnt_i + CNT_WIDTH'(1);
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped tagged BTB with direction counters, invalidate sweep, stats
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 64,
  parameter int unsigned N_ENTRIES = 16,
  parameter int unsigned TAG_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PC_WIDTH-1:0] lookup_pc_i,
  output logic                pred_hit_o,
  output logic                pred_taken_o,
  output logic [PC_WIDTH-1:0] pred_target_o,
  input  logic                upd_valid_i,
  input  logic [PC_WIDTH-1:0] upd_pc_i,
  input  logic [PC_WIDTH-1:0] upd_target_i,
  input  logic                upd_taken_i,
  input  logic                upd_pred_taken_i,
  input  logic                inv_req_i,
  output logic                busy_o,
  output logic [31:0]         stat_updates_o,
  output logic [31:0]         stat_mispredicts_o
);

  localparam int unsigned INDEX_BITS = $clog2(N_ENTRIES);
  localparam logic [CNT_WIDTH-1:0] THRESH  = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] WEAK_NT = THRESH - CNT_WIDTH'(1);

  logic [N_ENTRIES-1:0] valid_q;
  logic [TAG_WIDTH-1:0] tag_q    [N_ENTRIES];
  logic [PC_WIDTH-1:0]  target_q [N_ENTRIES];
  logic [CNT_WIDTH-1:0] cnt_q    [N_ENTRIES];

  btb_state_e           state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic [31:0]          stat_upd_q, stat_upd_d;
  logic [31:0]          stat_mis_q, stat_mis_d;

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_WIDTH-1:0]  lk_tag, up_tag;
  logic                  busy, lk_hit, up_hit, upd_accept;
  logic [CNT_WIDTH-1:0]  cnt_next;

  assign lk_idx = INDEX_BITS'(pc_index(PC_MAX_W'(lookup_pc_i), INDEX_BITS));
  assign lk_tag = TAG_WIDTH'(pc_tag(PC_MAX_W'(lookup_pc_i), INDEX_BITS, TAG_WIDTH));
  assign up_idx = INDEX_BITS'(pc_index(PC_MAX_W'(upd_pc_i), INDEX_BITS));
  assign up_tag = TAG_WIDTH'(pc_tag(PC_MAX_W'(upd_pc_i), INDEX_BITS, TAG_WIDTH));

  assign busy = (state_q == ST_CLEAR);

  // Lookup reads pre-update contents; there is deliberately no write bypass.
  assign lk_hit        = !busy && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_hit_o    = lk_hit;
  assign pred_taken_o  = lk_hit && (cnt_q[lk_idx] >= THRESH);
  assign pred_target_o = lk_hit ? target_q[lk_idx] : '0;

  assign upd_accept = upd_valid_i && !busy;
  assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  btb_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_sat_counter (
    .cnt_i(cnt_q[up_idx]),
    .up_i (upd_taken_i),
    .cnt_o(cnt_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= WEAK_NT;
      end
    end else begin
      if (upd_accept) begin
        if (up_hit) begin
          cnt_q[up_idx] <= cnt_next;
          if (upd_taken_i) target_q[up_idx] <= upd_target_i;
        end else if (upd_taken_i) begin
          valid_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= upd_target_i;
          cnt_q[up_idx]    <= THRESH;
        end
      end
      // Updates are blocked while sweeping, so this never collides with an allocate.
      if (busy) valid_q[ptr_q] <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (inv_req_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + INDEX_BITS'(1);
        if (ptr_q == INDEX_BITS'(N_ENTRIES - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stat_upd_d = stat_upd_q + 32'(upd_accept);
  assign stat_mis_d = stat_mis_q + 32'(upd_accept && (upd_taken_i != upd_pred_taken_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign busy_o             = busy;
  assign stat_updates_o     = stat_upd_q;
  assign stat_mispredicts_o = stat_mis_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - scoreboard bench for branch_target_buffer against a reference model
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] lookup_pc = '0;
  logic        pred_hit, pred_taken;
  logic [63:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [63:0] upd_pc = '0;
  logic [63:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic        upd_pred_taken = 1'b0;
  logic        inv_req = 1'b0;
  logic        busy;
  logic [31:0] stat_updates, stat_mispredicts;

  branch_target_buffer #(
    .PC_WIDTH (64),
    .N_ENTRIES(16),
    .TAG_WIDTH(8),
    .CNT_WIDTH(2)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .lookup_pc_i       (lookup_pc),
    .pred_hit_o        (pred_hit),
    .pred_taken_o      (pred_taken),
    .pred_target_o     (pred_target),
    .upd_valid_i       (upd_valid),
    .upd_pc_i          (upd_pc),
    .upd_target_i      (upd_target),
    .upd_taken_i       (upd_taken),
    .upd_pred_taken_i  (upd_pred_taken),
    .inv_req_i         (inv_req),
    .busy_o            (busy),
    .stat_updates_o    (stat_updates),
    .stat_mispredicts_o(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic        hit;
    logic        taken;
    logic [63:0] tgt;
    logic        busy;
    logic [31:0] su;
    logic [31:0] sm;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  string phase = "reset";

  // Reference model: 16 entries, 8-bit tags, 2-bit counters (THRESH 2, CMAX 3).
  bit          m_valid[16];
  int unsigned m_tag[16];
  logic [63:0] m_tgt[16];
  int          m_cnt[16];
  int          busy_left = 0;
  int unsigned m_upd = 0, m_mis = 0;
  bit          known = 0;

  function automatic int idx_of(logic [63:0] pc);
    return int'((pc >> 2) % 64'd16);
  endfunction

  function automatic int unsigned tag_of(logic [63:0] pc);
    return int'((pc >> 6) % 64'd256);
  endfunction

  function automatic exp_t expected();
    exp_t e;
    int i;
    bit h;
    i = idx_of(lookup_pc);
    h = (busy_left == 0) && m_valid[i] && (m_tag[i] == tag_of(lookup_pc));
    e.cyc   = cyc_cnt;
    e.name  = phase;
    e.hit   = h;
    e.taken = h && (m_cnt[i] >= 2);
    e.tgt   = h ? m_tgt[i] : 64'd0;
    e.busy  = (busy_left > 0);
    e.su    = m_upd;
    e.sm    = m_mis;
    return e;
  endfunction

  task automatic model_edge();
    int i;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = '0; m_cnt[k] = 1;
      end
      busy_left = 0; m_upd = 0; m_mis = 0; known = 1;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (upd_valid) begin
        i = idx_of(upd_pc);
        m_upd++;
        if (upd_taken != upd_pred_taken) m_mis++;
        if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
          if (upd_taken) begin
            m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
            m_tgt[i] = upd_target;
          end else begin
            m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
          end
        end else if (upd_taken) begin
          m_valid[i] = 1; m_tag[i] = tag_of(upd_pc); m_tgt[i] = upd_target; m_cnt[i] = 2;
        end
      end
      // The sweep's effect is observable only once it ends, so clear everything up front.
      if (inv_req) begin
        busy_left = 16;
        for (int k = 0; k < 16; k++) m_valid[k] = 0;
      end
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
      me = exp_q.pop_front();
      n_checks++;
      if (pred_hit === me.hit && pred_taken === me.taken && pred_target === me.tgt) n_pass++;
      else $display("FAIL lookup[%s] cyc %0d pc=%h: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h",
                    me.name, me.cyc, lookup_pc, pred_hit, pred_taken, pred_target, me.hit, me.taken, me.tgt);
      n_checks++;
      if (busy === me.busy && stat_updates === me.su && stat_mispredicts === me.sm) n_pass++;
      else $display("FAIL status[%s] cyc %0d: got busy=%b upd=%0d mis=%0d, want busy=%b upd=%0d mis=%0d",
                    me.name, me.cyc, busy, stat_updates, stat_mispredicts, me.busy, me.su, me.sm);
    end
  end

  task automatic tick();
    if (known) exp_q.push_back(expected());
    @(posedge clk);
    model_edge();
    #1;
    upd_valid = 1'b0;
    inv_req   = 1'b0;
  endtask

  task automatic set_upd(input logic [63:0] pc, input logic [63:0] tgt, input logic tk, input logic pt);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_pred_taken = pt;
  endtask

  task automatic look(input logic [63:0] pc);
    lookup_pc = pc;
    tick();
  endtask

  function automatic logic [63:0] rand_pc();
    logic [63:0] pc;
    pc = (64'($urandom_range(0, 3)) << 6) | (64'($urandom_range(0, 15)) << 2) | 64'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) pc = pc | ({$urandom, $urandom} << 14);
    return pc;
  endfunction

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    phase = "after_reset";
    look(64'h1000);

    phase = "alloc";
    set_upd(64'h1000, 64'h2000, 1'b1, 1'b0);
    look(64'h1000);
    look(64'h1000);

    phase = "counter";
    set_upd(64'h1000, 64'h2000, 1'b0, 1'b1); look(64'h1000);
    look(64'h1000);
    set_upd(64'h1000, 64'h2000, 1'b0, 1'b0); look(64'h1000);
    look(64'h1000);
    for (int k = 0; k < 3; k++) begin
      set_upd(64'h1000, 64'h2000 + 64'(k), 1'b1, 1'b0); look(64'h1000);
    end
    look(64'h1000);
    set_upd(64'h1000, 64'h9999, 1'b0, 1'b1); look(64'h1000);
    look(64'h1000);

    phase = "alias";
    set_upd(64'h1400, 64'h5000, 1'b1, 1'b1); look(64'h1400);
    look(64'h1000);
    look(64'h1400);

    phase = "stats";
    set_upd(64'h3000, 64'h7000, 1'b0, 1'b1); look(64'h3000);
    look(64'h3000);
    set_upd(64'h1400, 64'h5004, 1'b1, 1'b0); look(64'h1400);
    look(64'h1400);

    phase = "fill";
    for (int k = 0; k < 16; k++) begin
      set_upd(64'h8000 + 64'(k * 4), 64'hA000 + 64'(k), 1'b1, 1'b1);
      if (k == 15) inv_req = 1'b1;
      look(64'h8000 + 64'(k * 4));
    end
    phase = "sweep";
    for (int k = 0; k < 18; k++) begin
      if (k == 5) set_upd(64'h8010, 64'hBEEF, 1'b1, 1'b0);
      if (k == 7) inv_req = 1'b1;
      look(64'h8000 + 64'((k % 16) * 4));
    end
    phase = "post_sweep";
    for (int k = 0; k < 16; k++) look(64'h8000 + 64'(k * 4));

    phase = "rst_in_sweep";
    set_upd(64'h8008, 64'h1, 1'b1, 1'b1); look(64'h8008);
    inv_req = 1'b1; look(64'h8008);
    for (int k = 0; k < 4; k++) look(64'h8008);
    rst = 1'b1; look(64'h8008);
    rst = 1'b0;
    look(64'h8008);
    set_upd(64'h8008, 64'h2, 1'b1, 1'b0); look(64'h8008);
    look(64'h8008);

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 1)
        set_upd(rand_pc(), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) == 0) inv_req = 1'b1;
      rst = ($urandom_range(0, 999) == 0);
      look(rand_pc());
    end
    rst = 1'b0;
    look(64'h0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
